mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that drives the PC, IR, register file, ALU, extender, muxes and the MIO data bus.
- Sits beside the datapath in the CPU top. It takes OP/Funct from the held IR, Zero from the ALU, and MIO_ready from the bus.
- It stalls on memory handshakes and can optionally abort a hung bus access.

Parameters:
WAIT_LIMIT, 0, max cycles spent waiting for MIO_ready in one memory state; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
OP  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
MIO_ready  in  1  bus ready for current access
PCWrite  out  1  PC load enable (already qualified by branch condition)
IorD  out  1  memory address mux: 0 PC, 1 ALUOut
MemRead  out  1  bus read request
MemWrite  out  1  bus write request (drives DMWr)
IRWrite  out  1  IR load enable
RegWrite  out  1  RF write enable
RegDst  out  2  00 rd, 01 rt, 10 r31
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
ALUSrcA  out  1  0 PC, 1 rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 Imm32, 11 Imm32<<2
ALUOp  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA, 1010 LUI
EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump addr, 11 rs
state  out  4  current state, for debug
illegal  out  1  one-cycle pulse on an undecodable instruction
bus_err  out  1  one-cycle pulse on a WAIT_LIMIT timeout

Behaviour:
- Supported instructions:
  - R-type: add, sub, and, or, xor, nor, slt, sll, srl, sra, jr.
  - I-type: addi, slti, andi, ori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Encodings are the standard MIPS32 ones.
- States: IF=0, ID=1, EX=2, MRD=3, MWR=4, WBM=5, WBA=6, BR=7, JMP=8. States 9-15 are unreachable and go to IF next cycle with all enables 0.
- Outputs are Moore, decoded from state plus OP/Funct. Any signal not listed for a state is 0.
- Reset (reset=0) acts immediately:
  - state=IF, wait counter=0.
  - All outputs forced 0, including enables, illegal and bus_err.
  - The first fetch starts on the first rising edge after reset deasserts.
- IF:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite=PCWrite=MIO_ready.
  - Stays in IF while MIO_ready=0; goes to ID when it is 1.
- ID:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, EXTOp=01 (latches branch target).
  - Next state: beq/bne -> BR; j/jal/jr -> JMP; other legal instructions -> EX.
  - Illegal instruction -> IF, with illegal=1 for this cycle.
- EX:
  - ALUSrcA=1. ALUSrcB=00 for R-type, 10 otherwise.
  - ALUOp follows Funct/OP: add/addi/lw/sw ADD, sub SUB, and/andi AND, or/ori OR, slti SLT, lui LUI, and so on.
  - EXTOp: andi/ori 00, lui 10, others 01.
  - Next state: lw -> MRD; sw -> MWR; else -> WBA.
- MRD: MemRead=1, IorD=1. Holds until MIO_ready, then -> WBM.
- MWR: MemWrite=1, IorD=1. Holds until MIO_ready, then -> IF. MemWrite stays high for every cycle spent in MWR.
- WBM: RegWrite=1, RegDst=01, MemtoReg=01; -> IF.
- WBA: RegWrite=1, MemtoReg=00. RegDst=00 for R-type, 01 for I-type. -> IF.
- BR:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01.
  - PCWrite = Zero for beq, ~Zero for bne.
  - -> IF.
- JMP:
  - PCWrite=1. PCSource=10 for j/jal, 11 for jr.
  - jal additionally asserts RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4).
  - -> IF.
- Cycle counts per instruction (including all IF wait cycles): R/I ALU 4, lw 5, sw 4, branch/jump 3, plus any MIO wait cycles.
- Wait counter:
  - Counts cycles in IF/MRD/MWR with MIO_ready=0. Clears on state change.
  - If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT, bus_err pulses 1 cycle and the FSM goes to IF.
  - A timed-out fetch or store commits nothing.
  - MIO_ready arriving on the same cycle as the limit is hit wins: the access completes normally with no bus_err.
- Reset asserted mid-instruction aborts the instruction. No enable remains high during reset.

Test Plan:
- Reset, then MIO_ready=1, IR=add $3,$1,$2 (0x00221820) -> state sequence 0,1,2,6,0. In WBA: RegWrite=1, RegDst=00. ALUOp=0000 in EX.
- lw $5,8($0) (0x8C050008) with MIO_ready held low for 3 cycles in MRD -> MRD lasts 4 cycles, then WBM with RegDst=01, MemtoReg=01. Total 8 cycles.
- beq (0x10220003) with Zero=0, then bne (0x14220003) with Zero=0 -> PCWrite in BR is 0 then 1, PCSource=01.
- jal (0x0C000010) -> JMP state: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. jr $31 (0x03E00008) -> PCSource=11, RegWrite=0.
- OP=0x3F -> illegal=1 in ID and return to IF; no write enable asserted at any point.
- WAIT_LIMIT=4, sw with MIO_ready=0 forever -> bus_err pulses after 4 wait cycles, then IF. Also: reset=0 asserted mid-MWR -> MemWrite drops immediately and state=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute FSM with MIO bus
// handshakes and an optional bus-hang timeout (WAIT_LIMIT, 0 = wait forever).
//
// state | meaning
// IF    | fetch instruction, PC <= PC+4 when the bus answers
// ID    | decode, ALUOut <= branch target
// EX    | ALU operation / address computation
// MRD   | load data read
// MWR   | store data write
// WBM   | write MDR to register file
// WBA   | write ALUOut to register file
// BR    | branch compare and conditional PC load
// JMP   | j/jal/jr PC load (jal also links r31)
module mc_ctrl #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_MRD = 4'd3, S_MWR = 4'd4,
    S_WBM = 4'd5, S_WBA = 4'd6, S_BR = 4'd7, S_JMP = 4'd8
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_NOR = 4'd5,
                         ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                         ALU_SRA = 4'd9, ALU_LUI = 4'd10;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  state_t        state_q, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          is_r, is_lw, is_sw, is_beq, is_bne, is_jal, is_jump, is_logic_imm, is_lui;
  logic          r_ok, i_ok, legal, mem_wait, timeout;
  logic [3:0]    r_alu, i_alu;

  always_comb begin
    is_r         = (OP == 6'h00);
    is_lw        = (OP == 6'h23);
    is_sw        = (OP == 6'h2B);
    is_beq       = (OP == 6'h04);
    is_bne       = (OP == 6'h05);
    is_jal       = (OP == 6'h03);
    is_jump      = (OP == 6'h02) || is_jal || (is_r && Funct == 6'h08);
    is_logic_imm = (OP == 6'h0C) || (OP == 6'h0D);
    is_lui       = (OP == 6'h0F);
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (Funct)
      6'h20, 6'h08: r_alu = ALU_ADD;
      6'h22: r_alu = ALU_SUB;
      6'h24: r_alu = ALU_AND;
      6'h25: r_alu = ALU_OR;
      6'h26: r_alu = ALU_XOR;
      6'h27: r_alu = ALU_NOR;
      6'h2A: r_alu = ALU_SLT;
      6'h00: r_alu = ALU_SLL;
      6'h02: r_alu = ALU_SRL;
      6'h03: r_alu = ALU_SRA;
      default: r_ok = 1'b0;
    endcase
    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case (OP)
      6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03: i_alu = ALU_ADD;
      6'h0A: i_alu = ALU_SLT;
      6'h0C: i_alu = ALU_AND;
      6'h0D: i_alu = ALU_OR;
      6'h0F: i_alu = ALU_LUI;
      default: i_ok = 1'b0;
    endcase
    legal = is_r ? r_ok : i_ok;
  end

  // The cycle that would be the WAIT_LIMIT-th wait cycle times out unless ready arrives in it.
  assign mem_wait = (state_q == S_IF || state_q == S_MRD || state_q == S_MWR) && !MIO_ready;
  assign timeout  = (WAIT_LIMIT != 0) && mem_wait && (wait_cnt == CW'(WAIT_LIMIT - 1));

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IF:  state_nx = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        if (!legal)                state_nx = S_IF;
        else if (is_beq || is_bne) state_nx = S_BR;
        else if (is_jump)          state_nx = S_JMP;
        else                       state_nx = S_EX;
      end
      S_EX:  state_nx = is_lw ? S_MRD : (is_sw ? S_MWR : S_WBA);
      S_MRD: state_nx = MIO_ready ? S_WBM : (timeout ? S_IF : S_MRD);
      S_MWR: state_nx = (MIO_ready || timeout) ? S_IF : S_MWR;
      default: state_nx = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IF;
      wait_cnt <= '0;
    end else begin
      state_q <= state_nx;
      if (state_nx != state_q || timeout) wait_cnt <= '0;
      else if (mem_wait)                  wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign state = state_q;

  always_comb begin
    PCWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; RegWrite = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = ALU_ADD; EXTOp = 2'b00;
    PCSource = 2'b00; illegal = 1'b0; bus_err = 1'b0;
    // Everything stays low while reset is held, even though state_q already reads IF.
    if (reset) begin
      bus_err = timeout;
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MIO_ready;
          PCWrite = MIO_ready;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          EXTOp   = 2'b01;
          illegal = !legal;
        end
        S_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = is_r ? 2'b00 : 2'b10;
          ALUOp   = is_r ? r_alu : i_alu;
          EXTOp   = is_logic_imm ? 2'b00 : (is_lui ? 2'b10 : 2'b01);
        end
        S_MRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_WBM: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemtoReg = 2'b01;
        end
        S_WBA: begin
          RegWrite = 1'b1;
          RegDst   = is_r ? 2'b00 : 2'b01;
        end
        S_BR: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = 2'b01;
          PCWrite  = is_beq ? Zero : !Zero;
        end
        S_JMP: begin
          PCWrite  = 1'b1;
          PCSource = is_r ? 2'b11 : 2'b10;
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
